// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter (fetch / data) onto one shared memory port
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req, i_addr                 fetch request and byte address
//   i_rdata, i_ready              fetched word (registered), one-cycle completion pulse
//   d_rd, d_wr, d_addr, d_wdata   data read/write request, address, write data
//   d_rdata, d_ready              loaded word (registered), one-cycle completion pulse
//   stall_if, stall_mem           combinational stalls to the IF and MEM stages
//   mem_req, mem_we               shared memory request / write enable (registered)
//   mem_addr, mem_wdata           shared memory address / write data (registered)
//   mem_rdata, mem_ack            memory read data, one-cycle completion pulse
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     r_state;
  logic [2:0] r_streak;

  logic w_d_req;
  logic w_d_grant;

  assign w_d_req = d_rd | d_wr;
  // Data wins unless the fetch side has been starved for LIMIT grants.
  // With no fetch waiting, a saturated streak must not block data traffic.
  assign w_d_grant = w_d_req && ((r_streak < LIMIT) || !i_req);

  assign stall_if  = i_req & ~i_ready;
  assign stall_mem = w_d_req & ~d_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_streak  <= 3'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_d_grant) begin
            r_state   <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_wr;   // read+write together is a write
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            // Streak only grows while a fetch is actually waiting
            r_streak  <= i_req ? r_streak + 3'd1 : 3'd0;
          end else if (i_req) begin
            r_state   <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= 32'd0;
            r_streak  <= 3'd0;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            r_state <= RESP_I;
            mem_req <= 1'b0;
            i_rdata <= mem_rdata;
            i_ready <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            r_state <= RESP_D;
            mem_req <= 1'b0;
            if (!mem_we) d_rdata <= mem_rdata;
            d_ready <= 1'b1;
          end
        end
        RESP_I, RESP_D: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_rd, d_wr;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ready;
  logic        stall_if, stall_mem;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic        drd;
    logic        dwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] ack_data;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_timeout", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic respond(input int k, input logic [31:0] data, input logic [31:0] exp_addr);
    for (int c = 1; c < k; c++) begin
      tick();
      chk("hold_req", {31'd0, mem_req}, 32'd1);
      chk("hold_addr", mem_addr, exp_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
  endtask

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_ack = 0;

    // fetch 0x40, 1-cycle ack
    vecs[0] = '{1, 0, 0, 32'h40,  32'h0,        1, 32'h8C010010, 0, 32'h0,        32'h8C010010, 32'h0};
    // write 0x20, 3-cycle ack; d_rdata untouched
    vecs[1] = '{0, 0, 1, 32'h20,  32'hDEADBEEF, 3, 32'h55555555, 1, 32'hDEADBEEF, 32'h8C010010, 32'h0};
    // read 0x100, 2-cycle ack
    vecs[2] = '{0, 1, 0, 32'h100, 32'h0,        2, 32'h12345678, 0, 32'h0,        32'h8C010010, 32'h12345678};
    // read+write together -> write
    vecs[3] = '{0, 1, 1, 32'h24,  32'hCAFEF00D, 1, 32'hFFFFFFFF, 1, 32'hCAFEF00D, 32'h8C010010, 32'h12345678};
    // fetch 0x44, 2-cycle ack; d_rdata holds
    vecs[4] = '{1, 0, 0, 32'h44,  32'h0,        2, 32'hA5A5A5A5, 0, 32'h0,        32'hA5A5A5A5, 32'h12345678};

    tick(); tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      i_req = vecs[v].ireq; d_rd = vecs[v].drd; d_wr = vecs[v].dwr;
      i_addr = vecs[v].addr; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      #1;
      chk("stall_if_req", {31'd0, stall_if}, {31'd0, vecs[v].ireq});
      chk("stall_mem_req", {31'd0, stall_mem}, {31'd0, vecs[v].drd | vecs[v].dwr});
      wait_grant();
      chk("tbl_addr", mem_addr, vecs[v].addr);
      chk("tbl_we", {31'd0, mem_we}, {31'd0, vecs[v].exp_we});
      if (vecs[v].exp_we) chk("tbl_wdata", mem_wdata, vecs[v].exp_wdata);
      respond(vecs[v].ack_dly, vecs[v].ack_data, vecs[v].addr);
      chk("tbl_mem_req_drop", {31'd0, mem_req}, 32'd0);
      chk("tbl_i_ready", {31'd0, i_ready}, {31'd0, vecs[v].ireq});
      chk("tbl_d_ready", {31'd0, d_ready}, {31'd0, ~vecs[v].ireq});
      chk("tbl_i_rdata", i_rdata, vecs[v].exp_irdata);
      chk("tbl_d_rdata", d_rdata, vecs[v].exp_drdata);
      chk("tbl_stall_off", {30'd0, stall_if, stall_mem}, 32'd0);
      i_req = 0; d_rd = 0; d_wr = 0;
      tick();
      chk("tbl_ready_pulse", {30'd0, i_ready, d_ready}, 32'd0);
    end

    // stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'd0;
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    chk("stray_ready", {30'd0, i_ready, d_ready}, 32'd0);
    chk("stray_i_rdata", i_rdata, 32'hA5A5A5A5);
    chk("stray_d_rdata", d_rdata, 32'h12345678);
    tick();

    // simultaneous fetch and data read: data first
    i_req = 1; i_addr = 32'h80; d_rd = 1; d_addr = 32'h100;
    wait_grant();
    chk("prio_first_addr", mem_addr, 32'h100);
    chk("prio_stall_if1", {31'd0, stall_if}, 32'd1);
    respond(1, 32'h11, 32'h100);
    chk("prio_d_ready", {31'd0, d_ready}, 32'd1);
    chk("prio_stall_if2", {31'd0, stall_if}, 32'd1);
    d_rd = 0;
    tick();
    chk("prio_stall_if3", {31'd0, stall_if}, 32'd1);
    wait_grant();
    chk("prio_second_addr", mem_addr, 32'h80);
    chk("prio_second_we", {31'd0, mem_we}, 32'd0);
    respond(1, 32'h22, 32'h80);
    chk("prio_i_ready", {31'd0, i_ready}, 32'd1);
    chk("prio_i_rdata", i_rdata, 32'h22);
    chk("prio_d_rdata", d_rdata, 32'h11);
    i_req = 0;
    tick();

    // starvation: 4 data grants then one fetch, then data again
    chk("starve_streak0", {29'd0, dut.r_streak}, 32'd0);
    i_req = 1; i_addr = 32'h500; d_rd = 1; d_addr = 32'h600;
    for (int g = 0; g < 6; g++) begin
      wait_grant();
      chk("starve_addr", mem_addr, (g == 4) ? 32'h500 : 32'h600);
      if (g == 3) chk("starve_streak_sat", {29'd0, dut.r_streak}, 32'd4);
      if (g == 4) chk("starve_streak_clr", {29'd0, dut.r_streak}, 32'd0);
      respond(1, 32'h1000 + g, mem_addr);
      if (g == 4) begin
        chk("starve_i_ready", {31'd0, i_ready}, 32'd1);
        i_req = 0;
      end else begin
        chk("starve_d_ready", {31'd0, d_ready}, 32'd1);
      end
      tick();
    end
    d_rd = 0;
    tick();

    // reset mid-BUSY_D, then late ack
    d_rd = 1; d_addr = 32'h300;
    wait_grant();
    rst = 1; d_rd = 0;
    tick();
    rst = 0;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_d_rdata", d_rdata, 32'd0);
    chk("mid_rst_i_rdata", i_rdata, 32'd0);
    mem_ack = 1; mem_rdata = 32'h77777777;
    tick();
    mem_ack = 0; mem_rdata = 0;
    chk("late_ack_ready", {30'd0, i_ready, d_ready}, 32'd0);
    chk("late_ack_d_rdata", d_rdata, 32'd0);
    tick();
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_ready2", {30'd0, i_ready, d_ready}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4 (range 1..7): max consecutive data grants while an instruction request waits.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 i_req  input  1  fetch read request; held until i_ready.
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_rdata  output  32  fetched word; registered.
REQ-007 i_ready  output  1  one-cycle pulse; fetch complete.
REQ-008 d_rd, d_wr  input  1 each  data read/write request; held until d_ready.
REQ-009 d_addr, d_wdata  input  32 each  data address, write data.
REQ-010 d_rdata  output  32  loaded word; registered.
REQ-011 d_ready  output  1  one-cycle pulse; data access complete.
REQ-012 stall_if, stall_mem  output  1 each  stall to IF and MEM stages.
REQ-013 mem_req, mem_we  output  1 each  shared memory request, write enable; registered.
REQ-014 mem_addr, mem_wdata  output  32 each  shared memory address, write data; registered.
REQ-015 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-016 mem_ack  input  1  one-cycle completion pulse from memory; any latency >= 1 cycle after mem_req rises.

Function
REQ-017 FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D; arbitration only in IDLE.
REQ-018 IDLE: data request (d_rd|d_wr) present and streak < STARVE_LIMIT -> BUSY_D; else i_req -> BUSY_I; else stay IDLE.
REQ-019 IDLE with streak == STARVE_LIMIT and i_req high -> BUSY_I even if data pending.
REQ-020 On entry to BUSY_x: mem_req=1, mem_addr/mem_we/mem_wdata latched from the granted requester, held stable until mem_ack.
REQ-021 mem_we = d_wr for data grants, 0 for fetch; d_rd and d_wr both high -> treated as write.
REQ-022 BUSY_x with mem_ack -> RESP_x; mem_req deasserts same edge; mem_rdata captured into i_rdata (BUSY_I) or d_rdata (BUSY_D, read only).
REQ-023 RESP_x: x_ready=1 for exactly that cycle, then IDLE unconditionally; requester drops or changes request the cycle after ready.
REQ-024 Minimum latency: request seen in IDLE at cycle t, ack at t+1 -> ready at t+2; requests cannot be re-granted before t+3.
REQ-025 i_rdata/d_rdata hold value until next capture; d_rdata unchanged by writes.
REQ-026 Streak counter (3 bits): +1 on each data grant made while i_req high; cleared on fetch grant or on data grant with i_req low; saturates at STARVE_LIMIT.
REQ-027 stall_if = i_req & ~i_ready; stall_mem = (d_rd|d_wr) & ~d_ready; combinational.
REQ-028 mem_ack outside BUSY_x ignored, no state change.
REQ-029 Request withdrawn mid-BUSY: transaction completes; ready still pulses.

Reset
REQ-030 rst high at posedge -> IDLE, streak=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_rdata=0, d_rdata=0, i_ready=0, d_ready=0; overrides all other inputs.
REQ-031 rst mid-transaction: outstanding access abandoned, no ready pulse; a late mem_ack after reset is ignored per REQ-028.

Verification
REQ-032 i_req, i_addr=0x40, mem ack 1 cycle later with 0x8C010010 -> mem_addr=0x40, mem_we=0; i_ready at t+2, i_rdata=0x8C010010.
REQ-033 i_req and d_rd (addr 0x100) together -> data served first, fetch issued after RESP_D; stall_if high throughout.
REQ-034 d_wr addr 0x20 data 0xDEADBEEF, 3-cycle ack -> mem_we=1, mem_wdata=0xDEADBEEF stable 3 cycles; d_ready once; d_rdata unchanged.
REQ-035 Continuous data requests plus i_req, STARVE_LIMIT=4 -> exactly 4 data grants then one fetch grant; streak returns to 0.
REQ-036 rst pulsed while BUSY_D, then late mem_ack -> all outputs at reset values, no d_ready, FSM stays IDLE.
REQ-037 d_rd and d_wr both high -> write issued (mem_we=1).
